// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// In-order pipeline scoreboard for the stages after decode.
// It tracks the valid, destination and write flag of every stage. A decoded
// instruction stalls while one of its read sources matches the destination of
// an in-flight writer inside the hazard window.
// Build option: define PIPELINE_HAZARD_CTRL_WB_BYPASS_EN when the register file
// writes through. The last stage then drops out of the hazard window.
module pipeline_hazard_ctrl #(
  parameter int STAGES         = 5,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_enable,
  input  logic                      i_dec_valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_src1_addr,
  input  logic                      i_src1_used,
  input  logic [REG_ADDR_WIDTH-1:0] i_src2_addr,
  input  logic                      i_src2_used,
  input  logic [REG_ADDR_WIDTH-1:0] i_dst_addr,
  input  logic                      i_dst_write,
  input  logic                      i_flush,
  output logic                      o_issue,
  output logic                      o_stall,
  output logic [STAGES-1:0]         o_stage_valid,
  output logic                      o_wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] o_wb_addr,
  output logic [COUNT_WIDTH-1:0]    o_stall_count
);

`ifdef PIPELINE_HAZARD_CTRL_WB_BYPASS_EN
  // The last stage is covered by register-file write-through.
  localparam int WIN = STAGES - 1;
`else
  localparam int WIN = STAGES;
`endif

  // Index 0 holds stage 1 and index STAGES-1 holds the writeback stage.
  logic [STAGES-1:0]         vld_p;
  logic [STAGES-1:0]         wr_p;
  logic [REG_ADDR_WIDTH-1:0] dst_p [STAGES];
  logic [COUNT_WIDTH-1:0]    stall_cnt;
  logic                      hazard;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  // Register 0 is never a real dependency, so a zero source never matches.
  function automatic logic src_hit(input logic                      used,
                                   input logic [REG_ADDR_WIDTH-1:0] src,
                                   input logic [REG_ADDR_WIDTH-1:0] dst);
    return used && (src != '0) && (src == dst);
  endfunction

  // Look for a read-after-write match against every writer in the window.
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < WIN; s++) begin
      if (vld_p[s] && wr_p[s] && (dst_p[s] != '0) &&
          (src_hit(i_src1_used, i_src1_addr, dst_p[s]) ||
           src_hit(i_src2_used, i_src2_addr, dst_p[s])))
        hazard = 1'b1;
    end
  end

  assign o_stall = i_dec_valid && hazard && !i_flush;
  assign o_issue = i_dec_valid && !hazard && !i_flush;

  // Stage 1 takes the decode slot, or a bubble when nothing issues.
  // Later stages always advance because there is no back-pressure past stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p     <= '0;
      wr_p      <= '0;
      stall_cnt <= '0;
      for (int s = 0; s < STAGES; s++) dst_p[s] <= '0;
    end else if (clk_enable) begin
      vld_p    <= {vld_p[STAGES-2:0], o_issue};
      wr_p     <= {wr_p[STAGES-2:0], i_dst_write};
      dst_p[0] <= i_dst_addr;
      for (int s = 1; s < STAGES; s++) dst_p[s] <= dst_p[s-1];
      if (o_stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign o_stage_valid = vld_p;
  assign o_wb_valid    = vld_p[STAGES-1] && wr_p[STAGES-1] && (dst_p[STAGES-1] != '0);
  assign o_wb_addr     = dst_p[STAGES-1];
  assign o_stall_count = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl.
// The reference model keeps a list of issued instructions with the enabled-edge
// number at which each one issued. Stage occupancy is the age of an
// instruction, and the hazard window is an age range.
module tb_pipeline_hazard_ctrl;
  localparam int STAGES = 5;
  localparam int AW     = 5;
  localparam int CW     = 4;
`ifdef PIPELINE_HAZARD_CTRL_WB_BYPASS_EN
  localparam int WIN = STAGES - 1;
`else
  localparam int WIN = STAGES;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0, clk_enable = 1'b0, i_dec_valid = 1'b0;
  logic [AW-1:0] i_src1_addr = '0, i_src2_addr = '0, i_dst_addr = '0;
  logic          i_src1_used = 1'b0, i_src2_used = 1'b0, i_dst_write = 1'b0, i_flush = 1'b0;
  logic          o_issue, o_stall, o_wb_valid;
  logic [STAGES-1:0] o_stage_valid;
  logic [AW-1:0] o_wb_addr;
  logic [CW-1:0] o_stall_count;

  pipeline_hazard_ctrl #(.STAGES(STAGES), .REG_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .i_dec_valid(i_dec_valid),
    .i_src1_addr(i_src1_addr), .i_src1_used(i_src1_used),
    .i_src2_addr(i_src2_addr), .i_src2_used(i_src2_used),
    .i_dst_addr(i_dst_addr), .i_dst_write(i_dst_write), .i_flush(i_flush),
    .o_issue(o_issue), .o_stall(o_stall), .o_stage_valid(o_stage_valid),
    .o_wb_valid(o_wb_valid), .o_wb_addr(o_wb_addr), .o_stall_count(o_stall_count));

  always #5 clk = ~clk;

  typedef struct {
    int            k;
    logic [AW-1:0] dst;
    logic          wr;
  } inst_t;

  inst_t q[$];
  int    ecnt    = 0;
  int    m_cnt   = 0;
  bit    mdl_ok  = 0;
  int    n_cmp   = 0;
  int    n_bad   = 0;
  logic          obs_issue, obs_stall, obs_wbv;
  logic [STAGES-1:0] obs_sv;
  logic [AW-1:0] obs_wba;
  logic [CW-1:0] obs_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit mdl_hazard(input logic [AW-1:0] s1, input logic u1,
                                    input logic [AW-1:0] s2, input logic u2);
    foreach (q[i]) begin
      int age;
      age = ecnt - q[i].k + 1;
      if (age >= 1 && age <= WIN && q[i].wr && q[i].dst != 0) begin
        if (u1 && s1 != 0 && s1 == q[i].dst) return 1;
        if (u2 && s2 != 0 && s2 == q[i].dst) return 1;
      end
    end
    return 0;
  endfunction

  // One clock: drive at the falling edge, check just after it, then update the model at the rising edge.
  task automatic step(input logic r, input logic en, input logic dv,
                      input logic [AW-1:0] s1, input logic u1,
                      input logic [AW-1:0] s2, input logic u2,
                      input logic [AW-1:0] d, input logic w, input logic fl);
    bit hz, e_issue, e_stall, e_wbv;
    logic [STAGES-1:0] e_sv;
    logic [AW-1:0] e_wba;
    @(negedge clk);
    rst = r; clk_enable = en; i_dec_valid = dv;
    i_src1_addr = s1; i_src1_used = u1; i_src2_addr = s2; i_src2_used = u2;
    i_dst_addr = d; i_dst_write = w; i_flush = fl;
    #1;
    obs_issue = o_issue; obs_stall = o_stall; obs_sv = o_stage_valid;
    obs_wbv = o_wb_valid; obs_wba = o_wb_addr; obs_cnt = o_stall_count;
    hz = mdl_hazard(s1, u1, s2, u2);
    e_issue = dv && !hz && !fl;
    e_stall = dv && hz && !fl;
    e_sv = '0; e_wbv = 0; e_wba = '0;
    foreach (q[i]) begin
      int age;
      age = ecnt - q[i].k + 1;
      e_sv[age-1] = 1'b1;
      if (age == STAGES) begin
        e_wba = q[i].dst;
        e_wbv = q[i].wr && (q[i].dst != 0);
      end
    end
    if (mdl_ok) begin
      chk("issue", 32'(obs_issue), 32'(e_issue));
      chk("stall", 32'(obs_stall), 32'(e_stall));
      chk("stage_valid", 32'(obs_sv), 32'(e_sv));
      chk("wb_valid", 32'(obs_wbv), 32'(e_wbv));
      if (e_wbv) chk("wb_addr", 32'(obs_wba), 32'(e_wba));
      chk("stall_count", 32'(obs_cnt), 32'(m_cnt));
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      m_cnt = 0;
      mdl_ok = 1;
    end else if (en) begin
      ecnt++;
      if (e_issue) q.push_back('{k: ecnt, dst: d, wr: w});
      while (q.size() > 0 && (ecnt - q[0].k + 1) > STAGES) void'(q.pop_front());
      if (e_stall && m_cnt < CMAX) m_cnt++;
    end
  endtask

  task automatic idle(input logic en);
    step(0, en, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int  stalls;
    bit  issued;
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // RAW on register 3: stall for the window depth, then issue.
    step(0, 1, 1, 0, 0, 0, 0, 3, 1, 0);
    stalls = 0; issued = 0;
    for (int i = 0; i < 12 && !issued; i++) begin
      step(0, 1, 1, 3, 1, 0, 0, 4, 1, 0);
      if (obs_issue) issued = 1;
      else if (obs_stall) stalls++;
    end
    chk("raw_stall_len", 32'(stalls), 32'(WIN));
    chk("raw_issued", 32'(issued), 32'd1);
    idle(1);
    chk("raw_stall_count", 32'(obs_cnt), 32'(WIN));

    // Register 0 as destination and source never stalls and never writes back.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 1, 0, 1, 5, 1, 0);
    chk("r0_no_stall", 32'(obs_stall), 32'd0);
    for (int i = 0; i < 6; i++) idle(1);

    // A flush overrides a src2 hazard while the producer keeps advancing.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 7, 1, 0);
    step(0, 1, 1, 0, 0, 7, 1, 2, 1, 1);
    chk("flush_issue", 32'(obs_issue), 32'd0);
    for (int i = 0; i < 5; i++) idle(1);

    // Back-to-back independent writers.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 1, 0, 0, 0, 0, 2, 1, 0);
    chk("b2b_sv1", 32'(obs_sv), 32'b00001);
    step(0, 1, 1, 0, 0, 0, 0, 3, 1, 0);
    chk("b2b_sv2", 32'(obs_sv), 32'b00011);
    idle(1);
    chk("b2b_sv3", 32'(obs_sv), 32'b00111);
    idle(1);
    chk("b2b_wb_edge4", 32'(obs_wbv), 32'd0);
    idle(1);
    chk("b2b_wb_edge5", 32'(obs_wbv), 32'd1);
    chk("b2b_wb_addr", 32'(obs_wba), 32'd1);

    // Reset in the middle of a stall, then freeze with the clock enable low.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 1, 0, 0, 0, 0, 2, 1, 0);
    step(0, 1, 1, 0, 0, 0, 0, 3, 1, 0);
    step(0, 1, 1, 3, 1, 0, 0, 4, 1, 0);
    step(1, 1, 1, 3, 1, 0, 0, 4, 1, 0);
    step(0, 1, 1, 0, 0, 0, 0, 6, 1, 0);
    chk("rst_sv", 32'(obs_sv), 32'd0);
    chk("rst_cnt", 32'(obs_cnt), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 0, 6, 1, 0);
    chk("freeze_sv", 32'(obs_sv), 32'b00001);

    // Randomized traffic with small register numbers so that hazards are common.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 9) < 9),
           AW'($urandom_range(0, 7)), 1'($urandom),
           AW'($urandom_range(0, 7)), 1'($urandom),
           AW'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
